// File: rtl/id_ex_pl_stage.sv
// ID/EX pipeline stage built as a two-entry elastic skid buffer.
// Decode pushes with id_valid/id_ready and execute pops with ex_valid/ex_ready.
// id_ready depends only on the state register, rst and flush, never on
// ex_ready, so no combinational path runs from the consumer back to the producer.
module id_ex_pl_stage #(
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 4,
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [OPC_W-1:0]   id_opcode,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]  id_extd_imm_off,
  input  logic [DATA_W-1:0]  id_rs1_data,
  input  logic [DATA_W-1:0]  id_rs2_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [OPC_W-1:0]   opcode_ex,
  output logic [RADDR_W-1:0] rd_ex,
  output logic [DATA_W-1:0]  imm_val_ex,
  output logic [DATA_W-1:0]  rs1_data_ex,
  output logic [DATA_W-1:0]  rs2_data_ex,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PLD_W = 3*DATA_W + RADDR_W + OPC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PLD_W-1:0] r_main;
  logic [PLD_W-1:0] r_skid;
  logic [CNT_W-1:0] r_stall;
  logic [PLD_W-1:0] w_in_pld;
  logic             w_in;
  logic             w_out;
  logic             w_stall;

  // Increment that sticks at the counter's maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    return v + 1'b1;
  endfunction

  assign w_in_pld = {id_rs2_data, id_rs1_data, id_extd_imm_off, id_rd, id_opcode};
  assign id_ready = !rst && !flush && (r_state != ST_FULL);
  assign ex_valid = (r_state != ST_EMPTY);
  assign w_in     = id_valid && id_ready;
  assign w_out    = ex_valid && ex_ready;
  assign w_stall  = ex_valid && !ex_ready && !flush;

  assign occupancy = r_state;
  assign stall_cnt = r_stall;
  assign {rs2_data_ex, rs1_data_ex, imm_val_ex, rd_ex, opcode_ex} = r_main;

  // Control: handshake-driven state transitions; flush empties the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_in && !w_out)      r_state <= ST_FULL;
          else if (!w_in && w_out) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_out) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  // Payload: main feeds execute, skid catches the entry that arrives while main is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      case (r_state)
        ST_EMPTY: if (w_in) r_main <= w_in_pld;
        ST_ONE: begin
          if (w_in && w_out)       r_main <= w_in_pld;
          else if (w_in && !w_out) r_skid <= w_in_pld;
        end
        ST_FULL:  if (w_out) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  // Back-pressure statistics: count cycles where a valid entry waits on execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_stall <= '0;
    else if (w_stall) r_stall <= sat_inc(r_stall);
  end

endmodule

// File: tb/tb_id_ex_pl_stage.sv
// Directed bench for id_ex_pl_stage with a FIFO scoreboard of accepted payloads.
// A second instance with a 2-bit stall counter shares the inputs to exercise saturation.
module tb_id_ex_pl_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        ex_ready = 1'b0;
  logic [3:0]  id_opcode = '0;
  logic [3:0]  id_rd = '0;
  logic [15:0] id_imm = '0;
  logic [15:0] id_rs1 = '0;
  logic [15:0] id_rs2 = '0;

  logic        id_ready, ex_valid;
  logic [3:0]  opcode_ex, rd_ex;
  logic [15:0] imm_val_ex, rs1_data_ex, rs2_data_ex;
  logic [1:0]  occupancy;
  logic [7:0]  stall_cnt;

  logic        id_ready2, ex_valid2;
  logic [3:0]  opcode_ex2, rd_ex2;
  logic [15:0] imm_val_ex2, rs1_data_ex2, rs2_data_ex2;
  logic [1:0]  occupancy2;
  logic [1:0]  stall_cnt2;

  int n_pass = 0;
  int n_total = 0;
  logic [55:0] sb[$];

  always #5 clk = ~clk;

  id_ex_pl_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_extd_imm_off(id_imm),
    .id_rs1_data(id_rs1), .id_rs2_data(id_rs2),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .opcode_ex(opcode_ex), .rd_ex(rd_ex), .imm_val_ex(imm_val_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  id_ex_pl_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready2),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_extd_imm_off(id_imm),
    .id_rs1_data(id_rs1), .id_rs2_data(id_rs2),
    .ex_valid(ex_valid2), .ex_ready(ex_ready),
    .opcode_ex(opcode_ex2), .rd_ex(rd_ex2), .imm_val_ex(imm_val_ex2),
    .rs1_data_ex(rs1_data_ex2), .rs2_data_ex(rs2_data_ex2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  function automatic logic [55:0] pack(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [15:0] imm, input logic [15:0] r1,
                                       input logic [15:0] r2);
    return {r2, r1, imm, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [15:0] imm, input logic [15:0] r1, input logic [15:0] r2);
    id_valid = v; id_opcode = op; id_rd = rd; id_imm = imm; id_rs1 = r1; id_rs2 = r2;
  endtask

  // One clock cycle: score the release, record the accept, then advance to the next negedge.
  task automatic cyc();
    logic        fl;
    logic [55:0] exp_pld;
    #1;
    if (!rst && ex_valid && ex_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        exp_pld = sb.pop_front();
        chk("sb_payload", {8'h0, rs2_data_ex, rs1_data_ex, imm_val_ex, rd_ex, opcode_ex},
            {8'h0, exp_pld});
      end
    end
    if (id_valid && id_ready) sb.push_back(pack(id_opcode, id_rd, id_imm, id_rs1, id_rs2));
    fl = flush;
    @(posedge clk);
    if (fl || rst) sb.delete();
    @(negedge clk);
  endtask

  initial begin
    // Reset values while rst is held
    #2 rst = 1'b1;
    #1;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_id_ready", 64'(id_ready), 64'd0);
    chk("rst_payload", {8'h0, rs2_data_ex, rs1_data_ex, imm_val_ex, rd_ex, opcode_ex}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("id_ready_after_rst", 64'(id_ready), 64'd1);

    // Single instruction streamed straight through
    ex_ready = 1'b1;
    drive(1'b1, 4'h3, 4'h5, 16'h00FF, 16'h1234, 16'hABCD);
    cyc();
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
    chk("stream_valid", 64'(ex_valid), 64'd1);
    chk("stream_occ", 64'(occupancy), 64'd1);
    chk("stream_opcode", 64'(opcode_ex), 64'h3);
    chk("stream_rd", 64'(rd_ex), 64'h5);
    chk("stream_imm", 64'(imm_val_ex), 64'h00FF);
    chk("stream_rs1", 64'(rs1_data_ex), 64'h1234);
    chk("stream_rs2", 64'(rs2_data_ex), 64'hABCD);
    cyc();
    chk("stream_drained", 64'(ex_valid), 64'd0);

    // Back-pressure fills the skid register
    ex_ready = 1'b0;
    drive(1'b1, 4'h1, 4'h1, 16'h0011, 16'd1, 16'h0A0A);
    cyc();
    drive(1'b1, 4'h2, 4'h2, 16'h0022, 16'd2, 16'h0B0B);
    cyc();
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
    #1;
    chk("bp_occ_full", 64'(occupancy), 64'd2);
    chk("bp_id_ready", 64'(id_ready), 64'd0);
    chk("bp_hold_A", 64'(rs1_data_ex), 64'd1);
    cyc();
    chk("bp_still_A", 64'(rs1_data_ex), 64'd1);
    ex_ready = 1'b1;
    cyc();
    chk("bp_then_B", 64'(rs1_data_ex), 64'd2);
    chk("bp_occ_one", 64'(occupancy), 64'd1);
    cyc();
    chk("bp_empty", 64'(ex_valid), 64'd0);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd2);

    // Simultaneous accept and release keeps occupancy at one
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'h7, 4'(i), 16'(i * 3), 16'(i), 16'(16'hF000 + i));
      cyc();
      chk("thru_occ", 64'(occupancy), 64'd1);
      chk("thru_rs1", 64'(rs1_data_ex), 64'(i));
    end
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
    cyc();
    chk("thru_empty", 64'(ex_valid), 64'd0);

    // Flush while full with an instruction offered
    ex_ready = 1'b0;
    drive(1'b1, 4'h4, 4'h6, 16'h0C0C, 16'h0020, 16'h1111);
    cyc();
    drive(1'b1, 4'h5, 4'h7, 16'h0D0D, 16'h0021, 16'h2222);
    cyc();
    drive(1'b1, 4'h6, 4'h8, 16'h0E0E, 16'h0022, 16'h3333);
    flush = 1'b1;
    #1 chk("flush_id_ready", 64'(id_ready), 64'd0);
    cyc();
    flush = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
    chk("flush_ex_valid", 64'(ex_valid), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    ex_ready = 1'b1;
    repeat (3) begin
      cyc();
      chk("flush_no_ghost", 64'(ex_valid), 64'd0);
    end
    chk("flush_stall_kept", 64'(stall_cnt), 64'd3);

    // Stall counter saturation on the 2-bit instance
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ex_ready = 1'b0;
    drive(1'b1, 4'h9, 4'h9, 16'h0909, 16'h0909, 16'h0909);
    cyc();
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("sat_cnt2", 64'(stall_cnt2), (k < 3) ? 64'(k + 1) : 64'd3);
      chk("sat_cnt8", 64'(stall_cnt), 64'(k + 1));
    end
    ex_ready = 1'b1;
    cyc();
    chk("sat_drained", 64'(ex_valid), 64'd0);

    // Asynchronous reset between edges while full
    ex_ready = 1'b0;
    drive(1'b1, 4'hA, 4'hA, 16'h0A0A, 16'h00A0, 16'h0A0A);
    cyc();
    drive(1'b1, 4'hB, 4'hB, 16'h0B0B, 16'h00B0, 16'h0B0B);
    cyc();
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
    chk("arst_pre_occ", 64'(occupancy), 64'd2);
    #3 rst = 1'b1;
    #1;
    chk("arst_ex_valid", 64'(ex_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    chk("arst_id_ready", 64'(id_ready), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b1;
    cyc();
    chk("arst_after", 64'(ex_valid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_pl_stage.md
Name: id_ex_pl_stage

Overview:
Parametrised, elastic ID/EX pipeline stage for the RISC core. It replaces a plain always-loading register with a two-entry skid buffer that uses a valid/ready handshake on both sides. It supports a synchronous flush for branch mispredict and exceptions, and reports occupancy and stall statistics. It sits between the decode stage (producer) and the execute stage (consumer) and carries opcode, destination register, extended immediate and both source operands.

Parameters:
DATA_W, 16, width of rs1/rs2 data and extended immediate
OPC_W, 4, opcode width
RADDR_W, 4, destination register address width
CNT_W, 8, width of the saturating stall counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous flush; discards all held entries
id_valid  input  1  decode presents a valid instruction
id_ready  output  1  stage can accept an instruction this cycle
id_opcode  input  OPC_W  decoded opcode
id_rd  input  RADDR_W  destination register
id_extd_imm_off  input  DATA_W  sign/zero-extended immediate or offset
id_rs1_data  input  DATA_W  source operand 1
id_rs2_data  input  DATA_W  source operand 2
ex_valid  output  1  output entry is valid
ex_ready  input  1  execute consumes the output entry this cycle
opcode_ex  output  OPC_W  opcode of the output entry
rd_ex  output  RADDR_W  destination register of the output entry
imm_val_ex  output  DATA_W  immediate of the output entry
rs1_data_ex  output  DATA_W  operand 1 of the output entry
rs2_data_ex  output  DATA_W  operand 2 of the output entry
occupancy  output  2  number of held entries (0..2)
stall_cnt  output  CNT_W  saturating count of back-pressure cycles

Behaviour:
- Reset: asynchronous and active-high. While rst is high, all storage and outputs are 0: ex_valid=0, occupancy=0, stall_cnt=0, all payload outputs 0, id_ready=0. Reset mid-operation drops all entries immediately.
- Storage: a main register (drives the ex outputs) and a skid register. Each holds a packed {rs2, rs1, imm, rd, opcode} payload.
- Accept: in = id_valid && id_ready. Release: out = ex_valid && ex_ready.
- id_ready = !rst && !flush && (state != FULL). It is combinational from the state register, rst and flush. It never depends on ex_ready, so there is no combinational path from ex_ready to id_ready.
- States:
  - EMPTY (occupancy 0, ex_valid=0)
  - ONE (occupancy 1, ex_valid=1)
  - FULL (occupancy 2, ex_valid=1)
- Transitions (no flush):
  - EMPTY: in -> main<=input, go to ONE. Otherwise stay.
  - ONE: in && out -> main<=input, stay ONE. in && !out -> skid<=input, go to FULL. !in && out -> go to EMPTY. Neither -> hold.
  - FULL: out -> main<=skid, go to ONE. Otherwise hold. No accept is possible in FULL.
- Latency: an instruction accepted at edge N appears on the ex outputs with ex_valid=1 after edge N (one cycle) when the stage was EMPTY, or when ONE with a simultaneous release.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush or reset.
- Payload outputs are stable while ex_valid && !ex_ready.
- Flush (synchronous, highest priority after rst):
  - Next state is EMPTY and ex_valid=0 on the following cycle.
  - Input in the same cycle is not accepted (id_ready=0).
  - An output release in the same cycle is still counted as consumed by the consumer.
  - Payload registers hold their old values; they are don't-care while invalid.
  - stall_cnt is not cleared by flush.
- stall_cnt increments by 1 on each edge where ex_valid && !ex_ready and no flush. It saturates at 2^CNT_W-1 and never wraps. It is cleared only by rst.
- occupancy is registered and equals the state encoding: EMPTY=0, ONE=1, FULL=2.

Test Plan:
- Reset then stream: rst pulse; ex_ready=1; present opcode 4'h3, rd 4'h5, imm 16'h00FF, rs1 16'h1234, rs2 16'hABCD with id_valid=1 for one cycle -> next cycle ex_valid=1 with exactly those values, occupancy=1. Following cycle ex_valid=0.
- Back-pressure: ex_ready=0; send instructions A (rs1=1) and B (rs1=2) on consecutive cycles -> occupancy=2, id_ready=0, ex outputs hold A. Raise ex_ready -> A, then B, on consecutive cycles; stall_cnt equals the number of ex_ready=0 cycles with ex_valid=1.
- Simultaneous in/out in ONE: ex_ready=1 and id_valid=1 every cycle for 10 instructions with rs1=0..9 -> occupancy stays 1 and rs1_data_ex sequences 0..9 with no gaps.
- Flush in FULL while id_valid=1 -> id_ready=0 that cycle; next cycle ex_valid=0, occupancy=0. The input presented that cycle never appears at the output.
- Saturation with CNT_W=2: hold ex_ready=0 for 6 cycles with one entry held -> stall_cnt reads 1,2,3,3,3,3.
- Async reset mid-burst: assert rst between clock edges while FULL -> ex_valid, occupancy and stall_cnt read 0 immediately, before the next edge.
